// File: rtl/idecode32_stage.sv
`default_nettype none
// ============================================================================
// Module   : idecode32_stage
// Purpose  : Instruction decode stage of the Minisys 32-bit MIPS pipeline.
//            Holds the IF/ID pipeline register (with stall and flush), the
//            32x32 register file with a write-back port and a jal link port,
//            same-cycle write-through bypass on both read ports, and the
//            immediate extender for the execute stage.
// Ports    : clock, reset (async, active-high)
//            Instruction/PC_plus_4/opcplus4 - from fetch
//            Stall/Flush                    - IF/ID register control
//            Jal                            - link write of opcplus4 to $31
//            RegWrite/Wr_reg/Wr_data        - write-back port
//            ID_instruction/ID_pc_plus_4    - latched fetch outputs
//            Read_data_1/Read_data_2        - rs/rt operands (bypassed)
//            Sign_extend                    - extended immediate
//            Rs/Rt/Rd                       - register fields of ID_instruction
// Revision : 1.0 - initial release
// ============================================================================
module idecode32_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC_plus_4,
    input  logic [31:0] opcplus4,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Jal,
    input  logic        RegWrite,
    input  logic [4:0]  Wr_reg,
    input  logic [31:0] Wr_data,
    output logic [31:0] ID_instruction,
    output logic [31:0] ID_pc_plus_4,
    output logic [31:0] Read_data_1,
    output logic [31:0] Read_data_2,
    output logic [31:0] Sign_extend,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd
);

    localparam logic [4:0]  c_zero_reg = 5'd0;
    localparam logic [4:0]  c_link_reg = 5'd31;
    localparam logic [31:0] c_nop      = 32'h0000_0000;

    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_regs [0:31];

    logic [5:0]  w_opcode;
    logic        w_zero_ext;

    // ------------------------------------------------------------------
    // IF/ID pipeline register: flush beats stall, stall beats load.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id_instr <= c_nop;
            r_id_pc    <= '0;
        end else if (Flush) begin
            r_id_instr <= c_nop;
            r_id_pc    <= '0;
        end else if (!Stall) begin
            r_id_instr <= Instruction;
            r_id_pc    <= PC_plus_4;
        end
    end

    // ------------------------------------------------------------------
    // Register file. The link write is issued after the write-back write
    // so that, when both target $31, the later non-blocking assignment
    // (the link address) is the one that sticks. $0 is never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (RegWrite && (Wr_reg != c_zero_reg)) begin
                r_regs[Wr_reg] <= Wr_data;
            end
            if (Jal) begin
                r_regs[c_link_reg] <= opcplus4;
            end
        end
    end

    // Read with write-through bypass, same precedence as the write ports.
    function automatic logic [31:0] read_port(input logic [4:0] idx);
        logic [31:0] v;
        if (idx == c_zero_reg) begin
            v = '0;
        end else if (Jal && (idx == c_link_reg)) begin
            v = opcplus4;
        end else if (RegWrite && (idx == Wr_reg)) begin
            v = Wr_data;
        end else begin
            v = r_regs[idx];
        end
        return v;
    endfunction

    always_comb begin
        Read_data_1 = read_port(r_id_instr[25:21]);
        Read_data_2 = read_port(r_id_instr[20:16]);
    end

    // Logical immediates (andi/ori/xori/lui, opcodes 0x0C..0x0F) share the
    // 6'b0011xx pattern and are zero-extended; everything else sign-extends.
    assign w_opcode   = r_id_instr[31:26];
    assign w_zero_ext = (w_opcode[5:2] == 4'b0011);

    always_comb begin
        if (w_zero_ext) begin
            Sign_extend = {16'h0000, r_id_instr[15:0]};
        end else begin
            Sign_extend = {{16{r_id_instr[15]}}, r_id_instr[15:0]};
        end
    end

    assign ID_instruction = r_id_instr;
    assign ID_pc_plus_4   = r_id_pc;
    assign Rs             = r_id_instr[25:21];
    assign Rt             = r_id_instr[20:16];
    assign Rd             = r_id_instr[15:11];

endmodule
`default_nettype wire

// File: tb/tb_idecode32_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_idecode32_stage
// Purpose  : Self-checking bench for idecode32_stage: directed vector table,
//            hand-written reset/bypass/link sequences, and randomized traffic
//            compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idecode32_stage;

    logic        clock;
    logic        reset;
    logic [31:0] Instruction, PC_plus_4, opcplus4;
    logic        Stall, Flush, Jal, RegWrite;
    logic [4:0]  Wr_reg;
    logic [31:0] Wr_data;
    logic [31:0] ID_instruction, ID_pc_plus_4, Read_data_1, Read_data_2, Sign_extend;
    logic [4:0]  Rs, Rt, Rd;

    int n_pass  = 0;
    int n_total = 0;

    idecode32_stage dut (
        .clock          (clock),
        .reset          (reset),
        .Instruction    (Instruction),
        .PC_plus_4      (PC_plus_4),
        .opcplus4       (opcplus4),
        .Stall          (Stall),
        .Flush          (Flush),
        .Jal            (Jal),
        .RegWrite       (RegWrite),
        .Wr_reg         (Wr_reg),
        .Wr_data        (Wr_data),
        .ID_instruction (ID_instruction),
        .ID_pc_plus_4   (ID_pc_plus_4),
        .Read_data_1    (Read_data_1),
        .Read_data_2    (Read_data_2),
        .Sign_extend    (Sign_extend),
        .Rs             (Rs),
        .Rt             (Rt),
        .Rd             (Rd)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_regs [32];
    logic [31:0] m_id;
    logic [31:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_id = '0;
        m_pc = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (Jal && idx == 5'd31) return opcplus4;
        if (RegWrite && idx == Wr_reg) return Wr_data;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int op;
        int u;
        op = int'(ins[31:26]);
        u  = int'(ins[15:0]);
        if (op >= 12 && op <= 15) return 32'(u);
        if (u >= 32768) return 32'(u - 65536);
        return 32'(u);
    endfunction

    task automatic model_edge();
        if (RegWrite && Wr_reg != 0) m_regs[Wr_reg] = Wr_data;
        if (Jal) m_regs[31] = opcplus4;
        if (Flush) begin
            m_id = '0;
            m_pc = '0;
        end else if (!Stall) begin
            m_id = Instruction;
            m_pc = PC_plus_4;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        jal;
        logic [31:0] opc;
        logic [31:0] e_id;
        logic [31:0] e_pc;
        logic [31:0] e_imm;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t vt[$];

    function automatic logic [4:0] pick_reg();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 7) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        logic [31:0] e;
        logic [31:0] ins;
        logic [5:0]  opc6;
        model_reset();
        reset = 1'b1;
        Instruction = 32'h2008_0005;
        PC_plus_4 = 32'h0000_0400;
        opcplus4 = '0; Stall = 0; Flush = 0; Jal = 0; RegWrite = 0;
        Wr_reg = '0; Wr_data = '0;

        // ---------------- reset held 300 ns ----------------
        #310;
        check("reset id_instr", ID_instruction, 32'h0);
        check("reset id_pc", ID_pc_plus_4, 32'h0);
        check("reset rd1", Read_data_1, 32'h0);
        check("reset rd2", Read_data_2, 32'h0);
        check("reset imm", Sign_extend, 32'h0);
        check("reset rs/rt/rd", {17'h0, Rs, Rt, Rd}, 32'h0);
        reset = 1'b0;
        tick();
        check("post-reset id_instr", ID_instruction, 32'h2008_0005);
        check("post-reset rt", {27'h0, Rt}, 32'd8);
        check("post-reset imm", Sign_extend, 32'h0000_0005);
        check("post-reset id_pc", ID_pc_plus_4, 32'h0000_0400);

        // ---------------- vector table ----------------
        vt.push_back('{32'h3508_FFFF, 32'h1004, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h3508_FFFF, 32'h1004, 32'h0000_FFFF, 32'h0, 32'h0});
        vt.push_back('{32'h2108_FFFF, 32'h1008, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h2108_FFFF, 32'h1008, 32'hFFFF_FFFF, 32'h0, 32'h0});
        vt.push_back('{32'h0120_0000, 32'h100C, 0,0, 1,5'd9, 32'h1234_5678, 0,32'h0, 32'h0120_0000, 32'h100C, 32'h0, 32'h1234_5678, 32'h0});
        vt.push_back('{32'h0009_0000, 32'h1010, 0,0, 1,5'd0, 32'hFFFF_FFFF, 0,32'h0, 32'h0009_0000, 32'h1010, 32'h0, 32'h0, 32'h1234_5678});
        vt.push_back('{32'h03E0_0008, 32'h1014, 0,0, 1,5'd31, 32'hDEAD_BEEF, 1,32'h48, 32'h03E0_0008, 32'h1014, 32'h8, 32'h48, 32'h0});
        vt.push_back('{32'h03EA_0000, 32'h1018, 0,0, 1,5'd10, 32'hA5A5_A5A5, 1,32'h100, 32'h03EA_0000, 32'h1018, 32'h0, 32'h100, 32'hA5A5_A5A5});
        vt.push_back('{32'h1111_1111, 32'h101C, 1,0, 0,5'd0, 32'h0, 0,32'h0,   32'h03EA_0000, 32'h1018, 32'h0, 32'h100, 32'hA5A5_A5A5});
        vt.push_back('{32'h2222_2222, 32'h1020, 1,0, 1,5'd10, 32'h0BAD_F00D, 0,32'h0, 32'h03EA_0000, 32'h1018, 32'h0, 32'h100, 32'h0BAD_F00D});
        vt.push_back('{32'h3333_3333, 32'h1024, 1,0, 0,5'd0, 32'h0, 0,32'h0,   32'h03EA_0000, 32'h1018, 32'h0, 32'h100, 32'h0BAD_F00D});
        vt.push_back('{32'h4444_4444, 32'h1028, 1,1, 0,5'd0, 32'h0, 0,32'h0,   32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        vt.push_back('{32'h2008_0005, 32'h102C, 0,1, 0,5'd0, 32'h0, 0,32'h0,   32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        vt.push_back('{32'h3C0A_FFFF, 32'h1030, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h3C0A_FFFF, 32'h1030, 32'h0000_FFFF, 32'h0, 32'h0BAD_F00D});
        vt.push_back('{32'h8D2A_FF00, 32'h1034, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h8D2A_FF00, 32'h1034, 32'hFFFF_FF00, 32'h1234_5678, 32'h0BAD_F00D});
        vt.push_back('{32'h3000_8000, 32'h1038, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h3000_8000, 32'h1038, 32'h0000_8000, 32'h0, 32'h0});
        vt.push_back('{32'h3800_8001, 32'h103C, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h3800_8001, 32'h103C, 32'h0000_8001, 32'h0, 32'h0});
        vt.push_back('{32'h2800_8000, 32'h1040, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h2800_8000, 32'h1040, 32'hFFFF_8000, 32'h0, 32'h0});
        vt.push_back('{32'h4000_8000, 32'h1044, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h4000_8000, 32'h1044, 32'hFFFF_8000, 32'h0, 32'h0});
        vt.push_back('{32'h2C00_7FFF, 32'h1048, 0,0, 0,5'd0, 32'h0, 0,32'h0,   32'h2C00_7FFF, 32'h1048, 32'h0000_7FFF, 32'h0, 32'h0});

        foreach (vt[i]) begin
            Instruction = vt[i].instr; PC_plus_4 = vt[i].pc;
            Stall = vt[i].stall; Flush = vt[i].flush;
            RegWrite = vt[i].rw; Wr_reg = vt[i].wreg; Wr_data = vt[i].wdata;
            Jal = vt[i].jal; opcplus4 = vt[i].opc;
            tick();
            RegWrite = 0; Jal = 0; Stall = 0; Flush = 0;
            #1;
            e = vt[i].e_id;
            check($sformatf("vec%0d id_instr", i), ID_instruction, e);
            check($sformatf("vec%0d id_pc", i), ID_pc_plus_4, vt[i].e_pc);
            check($sformatf("vec%0d imm", i), Sign_extend, vt[i].e_imm);
            check($sformatf("vec%0d rd1", i), Read_data_1, vt[i].e_rd1);
            check($sformatf("vec%0d rd2", i), Read_data_2, vt[i].e_rd2);
            check($sformatf("vec%0d fields", i), {17'h0, Rs, Rt, Rd}, {17'h0, e[25:21], e[20:16], e[15:11]});
        end

        // ---------------- same-cycle bypass ----------------
        Instruction = 32'h01AE_0000;  // rs=13, rt=14
        tick();
        RegWrite = 1; Wr_reg = 5'd13; Wr_data = 32'hCAFE_F00D;
        #1;
        check("bypass rd1 same cycle", Read_data_1, 32'hCAFE_F00D);
        check("bypass rd2 unaffected", Read_data_2, 32'h0);
        tick();
        RegWrite = 0;
        #1;
        check("bypass rd1 stored", Read_data_1, 32'hCAFE_F00D);

        // ---------------- jal bypass beats write-back to $31 ----------------
        Instruction = 32'h03FF_0000;  // rs=rt=31
        tick();
        Jal = 1; opcplus4 = 32'h0000_0077;
        RegWrite = 1; Wr_reg = 5'd31; Wr_data = 32'hDEAD_BEEF;
        #1;
        check("jal bypass rd1", Read_data_1, 32'h0000_0077);
        check("jal bypass rd2", Read_data_2, 32'h0000_0077);
        tick();
        Jal = 0; RegWrite = 0;
        #1;
        check("jal stored $31", Read_data_1, 32'h0000_0077);

        // ---------------- async reset between edges ----------------
        Instruction = 32'h00A0_0000;  // rs=5
        RegWrite = 1; Wr_reg = 5'd5; Wr_data = 32'h55AA_55AA;
        tick();
        RegWrite = 0;
        #1;
        check("pre-reset $5", Read_data_1, 32'h55AA_55AA);
        #5;
        reset = 1'b1;
        model_reset();
        #1;
        check("async reset id_instr", ID_instruction, 32'h0);
        check("async reset rd1", Read_data_1, 32'h0);
        #19;
        reset = 1'b0;
        #1;
        check("after release id_instr", ID_instruction, 32'h0);
        check("after release rs", {27'h0, Rs}, 32'h0);
        tick();
        check("reload id_instr", ID_instruction, 32'h00A0_0000);
        check("reload $5 cleared", Read_data_1, 32'h0);

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) opc6 = 6'(12 + $urandom_range(0, 3));
            else opc6 = 6'($urandom_range(0, 63));
            ins = {opc6, pick_reg(), pick_reg(), 16'($urandom)};
            Instruction = ins;
            PC_plus_4   = $urandom;
            opcplus4    = $urandom;
            Stall       = ($urandom_range(0, 4) == 0);
            Flush       = ($urandom_range(0, 9) == 0);
            Jal         = ($urandom_range(0, 6) == 0);
            RegWrite    = ($urandom_range(0, 1) == 1);
            Wr_reg      = pick_reg();
            Wr_data     = $urandom;
            #1;
            check($sformatf("rand%0d rd1", n), Read_data_1, m_read(m_id[25:21]));
            check($sformatf("rand%0d rd2", n), Read_data_2, m_read(m_id[20:16]));
            tick();
            check($sformatf("rand%0d id_instr", n), ID_instruction, m_id);
            check($sformatf("rand%0d id_pc", n), ID_pc_plus_4, m_pc);
            check($sformatf("rand%0d imm", n), Sign_extend, m_imm(m_id));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
